// File: rtl/stc_ptr_gen.sv
// stc_ptr_gen: walks a sparse A tile row by row and emits 4-lane (row, slot)
// pointer beats for the compressed column slots of each nonzero row.
// Empty rows are skipped one per cycle, and a beat never spans two rows.
module stc_ptr_gen #(
    parameter int M      = 16,
    parameter int K      = 16,
    parameter int DW_COL = 4,
    parameter int DW_PTR = 8,
    parameter int DW_CNT = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [M*DW_CNT-1:0]   nnz_input,
    input  logic                  ptr_ready,
    output logic                  ptr_valid,
    output logic [DW_PTR*4-1:0]   ptrs,
    output logic [3:0]            lane_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SKIP, EMIT, DONE} stateE;

    localparam logic [DW_CNT-1:0] maxCount = DW_CNT'(K);
    localparam logic [DW_COL-1:0] lastRowIdx = DW_COL'(M - 1);

    stateE             state_q, state_d;
    logic [DW_COL-1:0] row_q, row_d;
    logic [DW_CNT-1:0] slot_q, slot_d;
    logic [DW_CNT-1:0] cnt_q [M];

    logic [DW_CNT-1:0] curCount;
    logic [DW_CNT-1:0] slotPlus4;
    logic              onLastRow;

    // Counts above K are meaningless for a K-slot compressed row, so saturate.
    function automatic logic [DW_CNT-1:0] clampCount(input logic [DW_CNT-1:0] c);
        return (c > maxCount) ? maxCount : c;
    endfunction

    assign curCount  = cnt_q[row_q];
    assign slotPlus4 = slot_q + DW_CNT'(4);
    assign onLastRow = (row_q == lastRowIdx);

    // State and walk position registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            slot_q  <= slot_d;
        end
    end

    // Snapshot the per-row counts on an accepted start so input changes mid-walk are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < M; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (state_q == IDLE && start) begin
            for (int r = 0; r < M; r++) begin
                cnt_q[r] <= clampCount(nnz_input[r*DW_CNT +: DW_CNT]);
            end
        end
    end

    // Next-state and next walk position: skip empty rows, step 4 slots per accepted beat.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SKIP;
                    row_d   = '0;
                    slot_d  = '0;
                end
            end
            SKIP: begin
                if (curCount == '0) begin
                    if (onLastRow) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + DW_COL'(1);
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (ptr_ready) begin
                    if (slotPlus4 < curCount) begin
                        slot_d = slotPlus4;
                    end else begin
                        slot_d = '0;
                        if (onLastRow) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + DW_COL'(1);
                            state_d = SKIP;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, so a stalled beat holds steady by construction.
    always_comb begin
        logic [DW_CNT-1:0] laneSlot;
        laneSlot   = '0;
        ptr_valid  = (state_q == EMIT);
        busy       = (state_q == SKIP) || (state_q == EMIT);
        done       = (state_q == DONE);
        lane_valid = '0;
        ptrs       = '0;
        if (state_q == EMIT) begin
            for (int g = 0; g < 4; g++) begin
                laneSlot = slot_q + DW_CNT'(g);
                if (laneSlot < curCount) begin
                    lane_valid[g]              = 1'b1;
                    ptrs[g*DW_PTR +: DW_PTR]   = DW_PTR'({row_q, laneSlot[DW_COL-1:0]});
                end
            end
        end
    end

endmodule

// File: doc/stc_ptr_gen.md
STC_PTR_GEN -- requirements
Module: stc_ptr_gen

Interface
REQ-001 Parameter M, default 16: rows per A tile.
REQ-002 Parameter K, default 16: max nonzeros per row; compressed column slots per row.
REQ-003 Parameter DW_COL, default 4: width of one row or slot index (log2 of max(M,K)).
REQ-004 Parameter DW_PTR, default 8: width of one lane pointer, equal to 2*DW_COL.
REQ-005 Parameter DW_CNT, default 5: width of one per-row nonzero count (holds 0..K).
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin a tile walk.
REQ-009 nnz_input  input  M*DW_CNT  per-row nonzero counts; row r at [r*DW_CNT +: DW_CNT].
REQ-010 ptr_ready  input  1  downstream A-buffer/MAC stage accepts the current beat.
REQ-011 ptr_valid  output  1  beat on ptrs/lane_valid is valid.
REQ-012 ptrs  output  DW_PTR*4  lane g pointer at [g*DW_PTR +: DW_PTR]: row in upper DW_COL bits, slot in lower DW_COL bits.
REQ-013 lane_valid  output  4  per-lane validity of ptrs.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse at walk completion.

Function
REQ-016 The block SHALL implement FSM states IDLE, SKIP, EMIT, DONE.
REQ-017 IDLE: start SHALL latch all nnz_input counts, clamping values >K to K, set row=0, slot=0, and go to SKIP; start in any other state SHALL be ignored.
REQ-018 SKIP: if row count is 0 and row<M-1, increment row, stay in SKIP (one row per cycle, no output); if row count is 0 and row=M-1, go to DONE; if nonzero, go to EMIT.
REQ-019 EMIT: ptr_valid=1; lanes g=0..3 carry (row, slot+g); lane_valid[g]=1 iff slot+g < count[row]; the beat never spans two rows.
REQ-020 A beat SHALL be accepted on a cycle with ptr_valid=1 and ptr_ready=1; no state changes in EMIT without acceptance.
REQ-021 While ptr_valid=1 and ptr_ready=0, ptrs and lane_valid SHALL hold stable.
REQ-022 On acceptance: if slot+4 < count[row], slot += 4, stay in EMIT; else slot=0, and if row=M-1 go to DONE, otherwise row += 1 and go to SKIP.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE and IDLE.
REQ-024 Outside EMIT, ptr_valid=0, lane_valid=0 and ptrs=0.
REQ-025 Invalid lanes in EMIT SHALL drive pointer 0.
REQ-026 Slot arithmetic SHALL be DW_CNT wide; (row, slot) pointer fields are truncated to DW_COL bits only at output.
REQ-027 Tile with all counts 0 SHALL produce no beats and pulse done M+1 cycles after start.
REQ-028 Latched counts SHALL be unaffected by nnz_input changes during a walk.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE, row=0, slot=0, clear latched counts, and drive ptr_valid=0, lane_valid=0, ptrs=0, busy=0, done=0, including mid-walk; no done pulse results from an aborted walk.
REQ-030 After reset release, the block SHALL accept start on the first cycle.

Verification
REQ-031 Counts row0=6, others 0, ptr_ready=1 -> beat (0,0..3) lane_valid=1111, beat (0,4..5) lane_valid=0011, then done after skipping rows 1..15.
REQ-032 Counts row3=4, row4=1, others 0 -> beats (3,0..3) 1111, then (4,0) 0001; no beat spans rows 3 and 4.
REQ-033 Count row0=16, ptr_ready toggled 1,0,0,1,... -> exactly 4 beats, slots 0,4,8,12; ptrs stable during every stall.
REQ-034 All counts 0 -> ptr_valid never asserts; done pulses M+1 cycles after start.
REQ-035 reset=0 asserted mid-EMIT on row 2 -> next cycle all outputs 0, IDLE; second start with row1=17 clamps to 16 -> 4 full beats.
REQ-036 start pulsed while busy -> ignored; beat sequence identical to the uninterrupted walk.
